uart_word_tx: RTL
=================

UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the line bit rate.
REQ-003 The block SHALL have derived parameter CLKS_PER_BIT, default CLK_HZ/BAUD with integer truncation (868), meaning the clock cycles per bit time; values below 2 are illegal.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_word  input  32  word to transmit.
REQ-007 The block SHALL have port i_valid  input  1  i_word is valid.
REQ-008 The block SHALL have port o_ready  output  1  block can accept a word this cycle.
REQ-009 The block SHALL have port o_tx  output  1  serial line, idle high.
REQ-010 The block SHALL have port o_busy  output  1  a word is being serialized.

Function
REQ-011 A word SHALL be accepted on a rising clk edge where i_valid and o_ready are both 1; i_word SHALL be latched on that edge.
REQ-012 o_ready SHALL be 1 only in state IDLE; i_valid without o_ready SHALL be ignored, with no queuing.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE->START on accept.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bit times.
- STOP->START if bytes remain, else STOP->IDLE, after CLKS_PER_BIT cycles.
REQ-014 Each byte SHALL be framed 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-015 Bytes SHALL be sent MSB byte first: i_word[31:24], [23:16], [15:8], [7:0].
REQ-016 Bytes SHALL be sent back-to-back, with no idle time between one stop bit and the next start bit.
REQ-017 o_tx SHALL go low in the first cycle after the accept edge, giving a latency of 1 cycle.
REQ-018 o_tx SHALL be a registered output, free of glitches.
REQ-019 After the final stop bit the block SHALL spend at least 1 cycle in IDLE with o_ready=1 before it can start again.
REQ-020 If i_valid is held high, the next word SHALL be accepted on that IDLE cycle.
REQ-021 o_busy SHALL equal NOT o_ready.
REQ-022 A change of i_word during transmission SHALL have no effect on the word being sent.
REQ-023 The bit-time counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload to 0 at each bit boundary.
REQ-024 The byte index SHALL count 0..3, or 0..4 with the terminator, and SHALL not wrap within a word.
REQ-025 Byte values 0x00, 0x0A and 0x0D inside the word SHALL be sent unmodified.

Reset
REQ-026 While rst_n=0 the block SHALL force o_tx=1, o_ready=0 and o_busy=1, and SHALL clear the FSM to IDLE and all counters and the data register to 0.
REQ-027 On the first rising edge with rst_n=1 the block SHALL set o_ready=1 and o_busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with o_tx driven high asynchronously and the remaining bytes discarded.

Configuration
REQ-029 With macro UART_TX_NEWLINE_EN defined, the block SHALL send a fifth byte 0x0A after byte [7:0], framed per REQ-014, so that one word occupies 50 bit times.
REQ-030 Without UART_TX_NEWLINE_EN, the block SHALL send exactly 4 bytes per word, so that one word occupies 40 bit times, and no terminator logic SHALL be present.

Verification
REQ-031 The bench SHALL use CLK_HZ=1000000 and BAUD=100000, giving CLKS_PER_BIT=10.
REQ-032 Single word: accept 0x41424344 -> o_tx shows bytes 0x41, 0x42, 0x43, 0x44 in 8N1 frames; o_ready returns high 400 cycles after accept (500 cycles with UART_TX_NEWLINE_EN, plus trailing 0x0A); line monitor decodes "ABCD".
REQ-033 Bit timing: accept 0x55AA00FF -> every o_tx transition is at a multiple of 10 cycles from the accept edge +1; no glitches; byte 0x00 is sent as 9 low bits then a stop bit.
REQ-034 Back-to-back: i_valid held with 0x01020304 then 0x05060708 -> exactly one IDLE cycle between the words; 8 (or 10) bytes decoded in order.
REQ-035 Ignored valid: pulse i_valid with 0xDEADBEEF while o_busy=1 -> word not sent, stream unchanged, o_ready stays low.
REQ-036 Reset mid-frame: assert rst_n=0 at cycle 125 of a word -> o_tx=1 within the same cycle; after release o_ready=1 and a fresh word 0x31323334 is sent correctly.

Source files
------------

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - 32-bit word to 8N1 UART serializer, MSB byte first.
// Optional UART_TX_NEWLINE_EN appends a 0x0A terminator byte to every word.
`timescale 1ns/1ps

module uart_word_tx #(
    parameter int CLK_HZ       = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_word,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_NEWLINE_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [31:0]      word_q, word_d;
    logic             tx_q, tx_d;
    logic             armed_q;
    logic [7:0]       cur_byte;
    logic [2:0]       bit_nxt;
    logic             bit_end;

    // armed_q keeps o_ready low throughout reset and rises on the first clean edge
    assign o_ready = (state == IDLE) && armed_q;
    assign o_busy  = ~o_ready;
    assign o_tx    = tx_q;
    assign bit_end = (cnt_q == CNT_MAX);
    assign bit_nxt = bit_q + 3'd1;

    always_comb begin
        cur_byte = 8'h00;
        case (byte_q)
            3'd0:    cur_byte = word_q[31:24];
            3'd1:    cur_byte = word_q[23:16];
            3'd2:    cur_byte = word_q[15:8];
            3'd3:    cur_byte = word_q[7:0];
`ifdef UART_TX_NEWLINE_EN
            3'd4:    cur_byte = 8'h0A;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            armed_q <= 1'b1;
        end
    end

    // tx_d is the level of the bit that begins on the coming edge, so o_tx is registered
    always_comb begin
        state_d = state;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        tx_d    = tx_q;
        case (state)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (i_valid && o_ready) begin
                    word_d  = i_word;
                    byte_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == LAST_BYTE) begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
